// File: rtl/tetris_pkg.sv
// Shared figure codes, controller state encoding and the tetromino spawn offsets.
package tetris_pkg;

   localparam int NUM_FIGS = 7;

   localparam int FIG_I = 0;
   localparam int FIG_O = 1;
   localparam int FIG_T = 2;
   localparam int FIG_S = 3;
   localparam int FIG_Z = 4;
   localparam int FIG_J = 5;
   localparam int FIG_L = 6;

   typedef enum logic [2:0] {
      StEmpty,
      StSpawnChk,
      StActive,
      StLocking,
      StOver
   } state_e;

   // Indexed [figure][j]; entry j describes cell 3-j (cell 3 first).
   localparam int SPAWN_DX [NUM_FIGS][4] = '{
      '{-1, 0, 1, 2},
      '{ 0, 0, 1, 1},
      '{-1, 0, 1, 0},
      '{ 0, 1,-1, 0},
      '{-1, 0, 0, 1},
      '{-1, 0, 1, 1},
      '{-1, 0, 1,-1}
   };

   localparam int SPAWN_Y [NUM_FIGS][4] = '{
      '{0, 0, 0, 0},
      '{0, 1, 0, 1},
      '{0, 0, 0, 1},
      '{0, 0, 1, 1},
      '{0, 0, 1, 1},
      '{0, 0, 0, 1},
      '{0, 0, 0, 1}
   };

endpackage

// File: rtl/piece_border_ctrl_spawn_table.sv
// Combinational figure -> spawn coordinates lookup; also used by the next-piece preview.
module spawn_table #(
   parameter int unsigned WIDTH   = 8,
   parameter int          SPAWN_X = 4
) (
   input  logic [WIDTH-1:0]   figure,
   output logic               valid,
   output logic [4*WIDTH-1:0] rst_x,
   output logic [4*WIDTH-1:0] rst_y
);
   import tetris_pkg::*;

   int fig;

   always_comb begin
      valid = (figure < WIDTH'(NUM_FIGS));
      fig   = 0;
      rst_x = '0;
      rst_y = '0;
      if (valid) begin
         fig = int'(figure);
         for (int j = 0; j < 4; j++) begin
            rst_x[(3-j)*WIDTH +: WIDTH] = WIDTH'(SPAWN_X + SPAWN_DX[fig][j]);
            rst_y[(3-j)*WIDTH +: WIDTH] = WIDTH'(SPAWN_Y[fig][j]);
         end
      end
   end

endmodule

// File: rtl/piece_border_ctrl.sv
// Active-piece / column-border bank with spawn collision check and lock sequencing.
// Define TETRIS_LOCK_PARALLEL_EN to merge all four cells into the border in one cycle.
module piece_border_ctrl #(
   parameter int unsigned MEM_WIDTH  = 10,
   parameter int unsigned MEM_HEIGHT = 20,
   parameter int unsigned WIDTH      = 8,
   parameter int          SPAWN_X    = int'(MEM_WIDTH / 2) - 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           figure,
   input  logic                       spawn_req,
   input  logic                       write_reg,
   input  logic                       lock_req,
   input  logic [4*WIDTH-1:0]         new_rho_x,
   input  logic [4*WIDTH-1:0]         new_rho_y,
   output logic [4*WIDTH-1:0]         rho_x,
   output logic [4*WIDTH-1:0]         rho_y,
   output logic [MEM_WIDTH*WIDTH-1:0] border,
   output logic                       busy,
   output logic                       spawn_done,
   output logic                       lock_done,
   output logic                       game_over
);
   import tetris_pkg::*;

   state_e           state;
   logic [WIDTH-1:0] col_top     [MEM_WIDTH];
   logic [WIDTH-1:0] col_top_nxt [MEM_WIDTH];
   logic             spawn_valid;
   logic [4*WIDTH-1:0] spawn_x;
   logic [4*WIDTH-1:0] spawn_y;
   logic             collide;
`ifndef TETRIS_LOCK_PARALLEL_EN
   logic [1:0]       cnt;
   logic [1:0]       cell_sel;
`endif

   spawn_table #(
      .WIDTH   (WIDTH),
      .SPAWN_X (SPAWN_X)
   ) u_spawn_table (
      .figure (figure),
      .valid  (spawn_valid),
      .rst_x  (spawn_x),
      .rst_y  (spawn_y)
   );

   always_comb begin
      border = '0;
      for (int c = 0; c < int'(MEM_WIDTH); c++) begin
         border[(int'(MEM_WIDTH)-1-c)*WIDTH +: WIDTH] = col_top[c];
      end
   end

   // Off-board columns never match any c, so such cells neither collide nor merge.
   always_comb begin
      collide = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < int'(MEM_WIDTH); c++) begin
            if (rho_x[k*WIDTH +: WIDTH] == WIDTH'(c) &&
                rho_y[k*WIDTH +: WIDTH] >= col_top[c]) begin
               collide = 1'b1;
            end
         end
      end
   end

`ifdef TETRIS_LOCK_PARALLEL_EN
   // Chained min so two cells sharing a column both take part.
   always_comb begin
      for (int c = 0; c < int'(MEM_WIDTH); c++) begin
         col_top_nxt[c] = col_top[c];
      end
      for (int k = 3; k >= 0; k--) begin
         for (int c = 0; c < int'(MEM_WIDTH); c++) begin
            if (rho_x[k*WIDTH +: WIDTH] == WIDTH'(c) &&
                rho_y[k*WIDTH +: WIDTH] < col_top_nxt[c]) begin
               col_top_nxt[c] = rho_y[k*WIDTH +: WIDTH];
            end
         end
      end
   end
`else
   always_comb begin
      cell_sel = 2'd3 - cnt;
      for (int c = 0; c < int'(MEM_WIDTH); c++) begin
         col_top_nxt[c] = col_top[c];
         if (rho_x[cell_sel*WIDTH +: WIDTH] == WIDTH'(c) &&
             rho_y[cell_sel*WIDTH +: WIDTH] < col_top[c]) begin
            col_top_nxt[c] = rho_y[cell_sel*WIDTH +: WIDTH];
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StEmpty;
         rho_x      <= '0;
         rho_y      <= '0;
         busy       <= 1'b0;
         spawn_done <= 1'b0;
         lock_done  <= 1'b0;
         game_over  <= 1'b0;
         for (int c = 0; c < int'(MEM_WIDTH); c++) begin
            col_top[c] <= WIDTH'(MEM_HEIGHT);
         end
`ifndef TETRIS_LOCK_PARALLEL_EN
         cnt <= 2'd0;
`endif
      end else begin
         spawn_done <= 1'b0;
         lock_done  <= 1'b0;
         unique case (state)
            StEmpty: begin
               if (spawn_req && spawn_valid) begin
                  rho_x <= spawn_x;
                  rho_y <= spawn_y;
                  busy  <= 1'b1;
                  state <= StSpawnChk;
               end
            end
            StSpawnChk: begin
               busy <= 1'b0;
               if (collide) begin
                  game_over <= 1'b1;
                  state     <= StOver;
               end else begin
                  spawn_done <= 1'b1;
                  state      <= StActive;
               end
            end
            StActive: begin
               if (lock_req) begin
                  busy  <= 1'b1;
                  state <= StLocking;
`ifndef TETRIS_LOCK_PARALLEL_EN
                  cnt <= 2'd0;
`endif
               end else if (write_reg) begin
                  rho_x <= new_rho_x;
                  rho_y <= new_rho_y;
               end
            end
            StLocking: begin
               col_top <= col_top_nxt;
`ifdef TETRIS_LOCK_PARALLEL_EN
               busy      <= 1'b0;
               lock_done <= 1'b1;
               state     <= StEmpty;
`else
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  busy      <= 1'b0;
                  lock_done <= 1'b1;
                  state     <= StEmpty;
               end
`endif
            end
            StOver: begin
            end
            default: state <= StEmpty;
         endcase
      end
   end

endmodule

// File: tb/tb_piece_border_ctrl.sv
// Directed, table-driven bench for piece_border_ctrl (honours TETRIS_LOCK_PARALLEL_EN).
module tb_piece_border_ctrl;
   localparam int MW = 10;
   localparam int MH = 20;
   localparam int W  = 8;
`ifdef TETRIS_LOCK_PARALLEL_EN
   localparam int LOCK_CYC = 1;
`else
   localparam int LOCK_CYC = 4;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [W-1:0] figure;
   logic spawn_req, write_reg, lock_req;
   logic [4*W-1:0] new_rho_x, new_rho_y, rho_x, rho_y;
   logic [MW*W-1:0] border;
   logic busy, spawn_done, lock_done, game_over;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [W-1:0]   fig;
      logic           ok;
      logic [4*W-1:0] x;
      logic [4*W-1:0] y;
   } vec_t;

   vec_t tbl [9];
   logic [W-1:0] eb [MW];

   localparam logic [4*W-1:0] T_X = {8'd3, 8'd4, 8'd5, 8'd4};
   localparam logic [4*W-1:0] T_Y = {8'd0, 8'd0, 8'd0, 8'd1};
   localparam logic [4*W-1:0] O_X = {8'd4, 8'd4, 8'd5, 8'd5};
   localparam logic [4*W-1:0] O_Y = {8'd0, 8'd1, 8'd0, 8'd1};
   localparam logic [4*W-1:0] I_X = {8'd3, 8'd4, 8'd5, 8'd6};

   always #5 clk = ~clk;

   piece_border_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .figure     (figure),
      .spawn_req  (spawn_req),
      .write_reg  (write_reg),
      .lock_req   (lock_req),
      .new_rho_x  (new_rho_x),
      .new_rho_y  (new_rho_y),
      .rho_x      (rho_x),
      .rho_y      (rho_y),
      .border     (border),
      .busy       (busy),
      .spawn_done (spawn_done),
      .lock_done  (lock_done),
      .game_over  (game_over)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [MW*W-1:0] pack_border(input logic [W-1:0] b [MW]);
      logic [MW*W-1:0] v;
      v = '0;
      for (int c = 0; c < MW; c++) v[(MW-1-c)*W +: W] = b[c];
      return v;
   endfunction

   task automatic eb_clear;
      for (int c = 0; c < MW; c++) eb[c] = W'(MH);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick;
      rst = 1'b0;
   endtask

   // Returns with the SPAWN_CHK edge just taken.
   task automatic spawn(input logic [W-1:0] f);
      figure    = f;
      spawn_req = 1'b1;
      tick;
      spawn_req = 1'b0;
      tick;
   endtask

   task automatic write_piece(input logic [4*W-1:0] x, input logic [4*W-1:0] y);
      new_rho_x = x;
      new_rho_y = y;
      write_reg = 1'b1;
      tick;
      write_reg = 1'b0;
   endtask

   task automatic lock_and_wait(input logic wr, input string name);
      int n;
      write_reg = wr;
      lock_req  = 1'b1;
      tick;
      write_reg = 1'b0;
      lock_req  = 1'b0;
      check({name, "_busy"}, 128'(busy), 128'(1));
      n = 0;
      while (!lock_done && n < 12) begin
         tick;
         n++;
      end
      check({name, "_latency"}, 128'(n), 128'(LOCK_CYC));
   endtask

   initial begin
      rst = 1'b0; figure = '0; spawn_req = 1'b0; write_reg = 1'b0; lock_req = 1'b0;
      new_rho_x = '0; new_rho_y = '0;

      tbl[0] = '{8'd0, 1'b1, I_X, {8'd0, 8'd0, 8'd0, 8'd0}};
      tbl[1] = '{8'd1, 1'b1, O_X, O_Y};
      tbl[2] = '{8'd2, 1'b1, T_X, T_Y};
      tbl[3] = '{8'd3, 1'b1, {8'd4, 8'd5, 8'd3, 8'd4}, {8'd0, 8'd0, 8'd1, 8'd1}};
      tbl[4] = '{8'd4, 1'b1, {8'd3, 8'd4, 8'd4, 8'd5}, {8'd0, 8'd0, 8'd1, 8'd1}};
      tbl[5] = '{8'd5, 1'b1, {8'd3, 8'd4, 8'd5, 8'd5}, T_Y};
      tbl[6] = '{8'd6, 1'b1, {8'd3, 8'd4, 8'd5, 8'd3}, T_Y};
      tbl[7] = '{8'd7, 1'b0, '0, '0};
      tbl[8] = '{8'd9, 1'b0, '0, '0};

      // Reset state
      do_reset;
      eb_clear;
      check("rst_rho_x", 128'(rho_x), 128'(0));
      check("rst_rho_y", 128'(rho_y), 128'(0));
      check("rst_border", 128'(border), 128'(pack_border(eb)));
      check("rst_flags", 128'({busy, spawn_done, lock_done, game_over}), 128'(0));

      // Spawn table, including invalid codes which must leave EMPTY untouched
      for (int i = 0; i < 9; i++) begin
         do_reset;
         figure    = tbl[i].fig;
         spawn_req = 1'b1;
         tick;
         spawn_req = 1'b0;
         check($sformatf("fig%0d_busy", tbl[i].fig), 128'(busy), 128'(tbl[i].ok));
         tick;
         check($sformatf("fig%0d_done", tbl[i].fig), 128'(spawn_done), 128'(tbl[i].ok));
         check($sformatf("fig%0d_x", tbl[i].fig), 128'(rho_x), 128'(tbl[i].x));
         check($sformatf("fig%0d_y", tbl[i].fig), 128'(rho_y), 128'(tbl[i].y));
         check($sformatf("fig%0d_over", tbl[i].fig), 128'(game_over), 128'(0));
      end

      // Write then sequenced lock
      do_reset;
      spawn(8'd2);
      check("t_spawn_done", 128'(spawn_done), 128'(1));
      write_piece(T_X, {8'd18, 8'd18, 8'd18, 8'd19});
      check("t_write_y", 128'(rho_y), 128'({8'd18, 8'd18, 8'd18, 8'd19}));
      check("t_done_pulse", 128'(spawn_done), 128'(0));
      lock_and_wait(1'b0, "lock1");
      eb_clear;
      eb[3] = 8'd18; eb[4] = 8'd18; eb[5] = 8'd18;
      check("lock1_border", 128'(border), 128'(pack_border(eb)));
      tick;
      check("lock1_pulse", 128'({lock_done, busy}), 128'(0));

      // Column 4 down to row 1, then an O spawn collides
      spawn(8'd2);
      write_piece({8'd4, 8'd4, 8'd4, 8'd4}, {8'd1, 8'd1, 8'd1, 8'd1});
      lock_and_wait(1'b0, "lock2");
      eb[4] = 8'd1;
      check("lock2_border", 128'(border), 128'(pack_border(eb)));
      tick;
      spawn(8'd1);
      check("over_flag", 128'(game_over), 128'(1));
      check("over_no_done", 128'(spawn_done), 128'(0));
      figure = 8'd2; spawn_req = 1'b1; write_reg = 1'b1; lock_req = 1'b1;
      new_rho_x = '0; new_rho_y = '0;
      repeat (3) tick;
      spawn_req = 1'b0; write_reg = 1'b0; lock_req = 1'b0;
      check("over_hold_x", 128'(rho_x), 128'(O_X));
      check("over_hold_y", 128'(rho_y), 128'(O_Y));
      check("over_hold_flags", 128'({busy, spawn_done, lock_done, game_over}), 128'(1));
      check("over_hold_border", 128'(border), 128'(pack_border(eb)));

      // Lock beats write in the same cycle
      do_reset;
      spawn(8'd2);
      new_rho_x = {8'd0, 8'd0, 8'd0, 8'd0};
      new_rho_y = {8'd9, 8'd9, 8'd9, 8'd9};
      lock_and_wait(1'b1, "lockwr");
      check("lockwr_x", 128'(rho_x), 128'(T_X));
      check("lockwr_y", 128'(rho_y), 128'(T_Y));
      eb_clear;
      eb[3] = 8'd0; eb[4] = 8'd0; eb[5] = 8'd0;
      check("lockwr_border", 128'(border), 128'(pack_border(eb)));

      // Reset in the middle of a lock discards the partial merge
      do_reset;
      spawn(8'd2);
      write_piece(T_X, {8'd18, 8'd18, 8'd18, 8'd19});
      lock_req = 1'b1;
      tick;
      lock_req = 1'b0;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      eb_clear;
      check("midrst_border", 128'(border), 128'(pack_border(eb)));
      check("midrst_rho", 128'({rho_x, rho_y}), 128'(0));
      check("midrst_flags", 128'({busy, spawn_done, lock_done, game_over}), 128'(0));
      spawn(8'd0);
      check("midrst_respawn", 128'({spawn_done, rho_x}), 128'({1'b1, I_X}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
